// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC APB register bank: register offsets, core command
// encodings and the APB protocol states.
package ecc_pkg;
  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_DATA_IN  = 5'h04;
  localparam logic [4:0] ADDR_CW_WIDTH = 5'h08;
  localparam logic [4:0] ADDR_NOISE    = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_RESULT   = 5'h14;
  localparam logic [4:0] ADDR_ERR_CNT  = 5'h18;

  typedef enum logic [1:0] {ENCODE = 2'd0, DECODE = 2'd1, FULL_CH = 2'd2} ctrl_e;
  typedef enum logic [1:0] {CW8 = 2'd0, CW16 = 2'd1, CW32 = 2'd2} cw_width_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_e;

  // Only the three defined commands launch the core; the fourth code is storage only.
  function automatic logic ctrl_starts(logic [1:0] v);
    return v <= FULL_CH;
  endfunction
endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module ecc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               cnt <= '0;
    else if (clr)                           cnt <= '0;
    else if (inc && cnt != {WIDTH{1'b1}})   cnt <= cnt + WIDTH'(1);
  end
endmodule

// File: rtl/ecc_apb_regfile.sv
// APB register bank and start/busy sequencer in front of the ECC core.
// Optional error counters at 0x18 are built when ECC_ERR_CNT_EN is defined.
module ecc_apb_regfile
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [1:0]                 ctrl,
  output logic [DATA_WIDTH-1:0]      data_in,
  output logic [1:0]                 codeword_width,
  output logic [DATA_WIDTH-1:0]      noise,
  output logic                       start,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  input  logic [DATA_WIDTH-1:0]      data_out
);
  apb_state_e state, state_nxt;
  logic wr_en, rd_en, cfg_wr, launch, done_cap, busy;
  logic [4:0] off;
  logic [1:0] nerr_cap;
  logic [DATA_WIDTH-1:0] result;
  logic [AMBA_WORD-1:0] rd_mux;
  logic unused_bits;

  assign off         = PADDR[4:0];
  assign unused_bits = ^{PADDR, PWDATA};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
      SETUP:   if (PENABLE) state_nxt = ACCESS;
               else if (PSEL) state_nxt = SETUP;
      ACCESS:  if (PSEL && !PENABLE) state_nxt = SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // The access phase is the cycle with PENABLE high after a SETUP; commit at its closing edge.
  always_comb begin
    wr_en = 1'b0;
    rd_en = PSEL && !PENABLE && !PWRITE;
    case (state)
      SETUP:   wr_en = PENABLE && PWRITE;
      default: wr_en = 1'b0;
    endcase
  end

  assign cfg_wr   = wr_en && !busy;
  assign launch   = cfg_wr && off == ADDR_CTRL && ctrl_starts(PWDATA[1:0]);
  assign done_cap = operation_done && busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl           <= '0;
      data_in        <= '0;
      codeword_width <= '0;
      noise          <= '0;
      start          <= 1'b0;
      busy           <= 1'b0;
      nerr_cap       <= '0;
      result         <= '0;
    end else begin
      start <= launch;
      if (cfg_wr) begin
        case (off)
          ADDR_CTRL:     ctrl           <= PWDATA[1:0];
          ADDR_DATA_IN:  data_in        <= DATA_WIDTH'(PWDATA);
          ADDR_CW_WIDTH: codeword_width <= PWDATA[1:0];
          ADDR_NOISE:    noise          <= DATA_WIDTH'(PWDATA);
          default: ;
        endcase
      end
      if (done_cap) begin
        busy     <= 1'b0;
        result   <= data_out;
        nerr_cap <= num_of_errors;
      end
      if (launch) busy <= 1'b1;
    end
  end

`ifdef ECC_ERR_CNT_EN
  logic [15:0] cnt_single, cnt_double;
  logic cnt_clr;
  assign cnt_clr = wr_en && off == ADDR_ERR_CNT;

  ecc_sat_counter #(.WIDTH(16)) u_cnt_single (
    .clk(clk), .rst(rst), .inc(done_cap && num_of_errors == 2'd1), .clr(cnt_clr), .cnt(cnt_single)
  );
  ecc_sat_counter #(.WIDTH(16)) u_cnt_double (
    .clk(clk), .rst(rst), .inc(done_cap && num_of_errors == 2'd2), .clr(cnt_clr), .cnt(cnt_double)
  );
`endif

  always_comb begin
    rd_mux = '0;
    case (off)
      ADDR_CTRL:     rd_mux = AMBA_WORD'(ctrl);
      ADDR_DATA_IN:  rd_mux = AMBA_WORD'(data_in);
      ADDR_CW_WIDTH: rd_mux = AMBA_WORD'(codeword_width);
      ADDR_NOISE:    rd_mux = AMBA_WORD'(noise);
      ADDR_STATUS:   rd_mux = AMBA_WORD'({23'b0, busy, 6'b0, nerr_cap});
      ADDR_RESULT:   rd_mux = AMBA_WORD'(result);
`ifdef ECC_ERR_CNT_EN
      ADDR_ERR_CNT:  rd_mux = AMBA_WORD'({cnt_double, cnt_single});
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       PRDATA <= '0;
    else if (rd_en) PRDATA <= rd_mux;
  end
endmodule
